// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the 5-stage RV32I pipeline.
// Priority of the pipeline controls is MemBusy > redirect (PCSrc_E) > load-use.
// Also keeps saturating stall/flush counters and a sticky data-memory timeout flag.
module hazard_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       RS_addr_D,
    input  logic [4:0]       RT_addr_D,
    input  logic [4:0]       RS_addr_E,
    input  logic [4:0]       RT_addr_E,
    input  logic [4:0]       RD_addr_E,
    input  logic [1:0]       ResultSrc_E,
    input  logic             PCSrc_E,
    input  logic             RegWrite_M,
    input  logic [4:0]       RD_addr_M,
    input  logic             RegWrite_W,
    input  logic [4:0]       RD_addr_W,
    input  logic             MemBusy,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             CLR_E,
    output logic [1:0]       Fwd_A_E,
    output logic [1:0]       Fwd_B_E,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        LU_STALL = 2'd2
    } state_t;

    localparam logic [1:0]       RES_LOAD    = 2'b01;
    localparam logic [1:0]       FWD_REG     = 2'b00;
    localparam logic [1:0]       FWD_WB      = 2'b01;
    localparam logic [1:0]       FWD_MEM     = 2'b10;
    localparam logic [7:0]       TIMEOUT_VAL = 8'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t     state;
    state_t     next_state;
    logic       lu;
    logic       redirect;
    logic [7:0] wait_cnt;
    logic [7:0] wait_next;

    // Load-use: the load in EX writes a register the decode instruction reads (x0 excluded).
    assign lu = (ResultSrc_E == RES_LOAD) && (RD_addr_E != 5'd0) &&
                ((RD_addr_E == RS_addr_D) || (RD_addr_E == RT_addr_D));

    // A redirect is only acted on when memory is not holding the pipeline.
    assign redirect = PCSrc_E && !MemBusy;

    // Pipeline controls in priority order; everything is forced low during reset.
    always_comb begin
        // NOTE: every output gets a default first so no path through this block infers a latch.
        Stall_F = 1'b0;
        Stall_D = 1'b0;
        Stall_E = 1'b0;
        Stall_M = 1'b0;
        Flush_D = 1'b0;
        CLR_E   = 1'b0;
        if (!RST) begin
            if (MemBusy) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Stall_E = 1'b1;
                Stall_M = 1'b1;
            end else if (PCSrc_E) begin
                Flush_D = 1'b1;
                CLR_E   = 1'b1;
            end else if (lu) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                CLR_E   = 1'b1;
            end
        end
    end

    // Operand forwarding: the younger producer in MEM wins over WB.
    always_comb begin
        Fwd_A_E = FWD_REG;
        Fwd_B_E = FWD_REG;
        if (!RST) begin
            if (RegWrite_M && (RD_addr_M != 5'd0) && (RD_addr_M == RS_addr_E))
                Fwd_A_E = FWD_MEM;
            else if (RegWrite_W && (RD_addr_W != 5'd0) && (RD_addr_W == RS_addr_E))
                Fwd_A_E = FWD_WB;

            if (RegWrite_M && (RD_addr_M != 5'd0) && (RD_addr_M == RT_addr_E))
                Fwd_B_E = FWD_MEM;
            else if (RegWrite_W && (RD_addr_W != 5'd0) && (RD_addr_W == RT_addr_E))
                Fwd_B_E = FWD_WB;
        end
    end

    // Next-state selection follows the same priority as the pipeline controls.
    always_comb begin
        next_state = RUN;
        case (state)
            RUN: begin
                if (MemBusy)        next_state = MEM_WAIT;
                else if (redirect)  next_state = RUN;
                else if (lu)        next_state = LU_STALL;
            end
            MEM_WAIT: begin
                if (MemBusy)        next_state = MEM_WAIT;
                else if (!redirect && lu) next_state = LU_STALL;
            end
            LU_STALL: begin
                // The bubble now in EX normally clears lu, so this returns to RUN.
                if (MemBusy)        next_state = MEM_WAIT;
                else if (!redirect && lu) next_state = LU_STALL;
            end
            default: next_state = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        // NOTE: reset is synchronous, sampled only on the rising edge like any other input.
        if (RST) state <= RUN;
        else     state <= next_state;
    end

    // Consecutive-busy counter value for the coming edge; saturates rather than wraps.
    always_comb begin
        wait_next = 8'd0;
        if (MemBusy)
            wait_next = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
    end

    // Busy-cycle counter and sticky timeout flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            wait_cnt <= wait_next;
            if (MemBusy && (wait_next == TIMEOUT_VAL))
                mem_timeout <= 1'b1;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (Stall_D && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_ONE;
            if (redirect && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed tests for hazard_ctrl, one task per scenario.
// A second instance with CNT_W=4 / TIMEOUT=3 shares the inputs for saturation checks.
module tb_hazard_ctrl;

    logic       CLK;
    logic       RST;
    logic [4:0] RS_addr_D, RT_addr_D, RS_addr_E, RT_addr_E, RD_addr_E;
    logic [1:0] ResultSrc_E;
    logic       PCSrc_E, RegWrite_M, RegWrite_W, MemBusy;
    logic [4:0] RD_addr_M, RD_addr_W;

    logic        Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, CLR_E;
    logic [1:0]  Fwd_A_E, Fwd_B_E;
    logic [31:0] stall_cnt, flush_cnt;
    logic        mem_timeout;

    logic        s4_F, s4_D, s4_E, s4_M, f4_D, c4_E;
    logic [1:0]  fa4, fb4;
    logic [3:0]  stall_cnt4, flush_cnt4;
    logic        mem_timeout4;

    int errors = 0;
    int checks = 0;

    hazard_ctrl dut (
        .CLK(CLK), .RST(RST),
        .RS_addr_D(RS_addr_D), .RT_addr_D(RT_addr_D),
        .RS_addr_E(RS_addr_E), .RT_addr_E(RT_addr_E), .RD_addr_E(RD_addr_E),
        .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E),
        .RegWrite_M(RegWrite_M), .RD_addr_M(RD_addr_M),
        .RegWrite_W(RegWrite_W), .RD_addr_W(RD_addr_W),
        .MemBusy(MemBusy),
        .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
        .Flush_D(Flush_D), .CLR_E(CLR_E),
        .Fwd_A_E(Fwd_A_E), .Fwd_B_E(Fwd_B_E),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
    );

    hazard_ctrl #(.CNT_W(4), .TIMEOUT(3)) dut4 (
        .CLK(CLK), .RST(RST),
        .RS_addr_D(RS_addr_D), .RT_addr_D(RT_addr_D),
        .RS_addr_E(RS_addr_E), .RT_addr_E(RT_addr_E), .RD_addr_E(RD_addr_E),
        .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E),
        .RegWrite_M(RegWrite_M), .RD_addr_M(RD_addr_M),
        .RegWrite_W(RegWrite_W), .RD_addr_W(RD_addr_W),
        .MemBusy(MemBusy),
        .Stall_F(s4_F), .Stall_D(s4_D), .Stall_E(s4_E), .Stall_M(s4_M),
        .Flush_D(f4_D), .CLR_E(c4_E),
        .Fwd_A_E(fa4), .Fwd_B_E(fb4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4), .mem_timeout(mem_timeout4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, CLR_E}
    wire [5:0] ctrl = {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, CLR_E};

    task automatic idle_inputs();
        RS_addr_D = 5'd0; RT_addr_D = 5'd0;
        RS_addr_E = 5'd0; RT_addr_E = 5'd0; RD_addr_E = 5'd0;
        ResultSrc_E = 2'b00; PCSrc_E = 1'b0;
        RegWrite_M = 1'b0; RD_addr_M = 5'd0;
        RegWrite_W = 1'b0; RD_addr_W = 5'd0;
        MemBusy = 1'b0;
    endtask

    // Advance one rising edge; inputs change and outputs are sampled at the falling edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1;
        MemBusy = 1'b1;
        RegWrite_M = 1'b1; RD_addr_M = 5'd3; RS_addr_E = 5'd3; RT_addr_E = 5'd3;
        tick(1);
        #1;
        checks++;
        if (ctrl !== 6'b000000) begin
            $display("FAIL reset_ctrl: got %b exp %b", ctrl, 6'b000000); errors++;
        end
        checks++;
        if ({Fwd_A_E, Fwd_B_E} !== 4'b0000) begin
            $display("FAIL reset_fwd: got %b exp %b", {Fwd_A_E, Fwd_B_E}, 4'b0000); errors++;
        end
        checks++;
        if ({stall_cnt, flush_cnt, mem_timeout} !== 65'd0) begin
            $display("FAIL reset_regs: stall=%0d flush=%0d to=%b exp 0 0 0",
                     stall_cnt, flush_cnt, mem_timeout); errors++;
        end
        RST = 1'b0;
        idle_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        ResultSrc_E = 2'b01; RD_addr_E = 5'd5; RS_addr_D = 5'd5; RT_addr_D = 5'd9;
        #1;
        checks++;
        if (ctrl !== 6'b110001) begin
            $display("FAIL lu_ctrl: got %b exp %b", ctrl, 6'b110001); errors++;
        end
        checks++;
        if (stall_cnt !== 32'd0) begin
            $display("FAIL lu_cnt_before: got %0d exp 0", stall_cnt); errors++;
        end
        tick(1);
        checks++;
        if (stall_cnt !== 32'd1) begin
            $display("FAIL lu_cnt_after: got %0d exp 1", stall_cnt); errors++;
        end
        // Bubble now in EX
        RD_addr_E = 5'd0; ResultSrc_E = 2'b00;
        #1;
        checks++;
        if (ctrl !== 6'b000000) begin
            $display("FAIL lu_bubble_ctrl: got %b exp %b", ctrl, 6'b000000); errors++;
        end
        tick(1);
        checks++;
        if (stall_cnt !== 32'd1) begin
            $display("FAIL lu_no_double: got %0d exp 1", stall_cnt); errors++;
        end
        // rs2 match also stalls
        ResultSrc_E = 2'b01; RD_addr_E = 5'd12; RS_addr_D = 5'd1; RT_addr_D = 5'd12;
        #1;
        checks++;
        if (ctrl !== 6'b110001) begin
            $display("FAIL lu_rs2_ctrl: got %b exp %b", ctrl, 6'b110001); errors++;
        end
        // non-load result select does not stall
        ResultSrc_E = 2'b10;
        #1;
        checks++;
        if (ctrl !== 6'b000000) begin
            $display("FAIL lu_nonload_ctrl: got %b exp %b", ctrl, 6'b000000); errors++;
        end
        idle_inputs();
    endtask

    task automatic test_x0_filter();
        do_reset();
        ResultSrc_E = 2'b01; RD_addr_E = 5'd0; RS_addr_D = 5'd0; RT_addr_D = 5'd0;
        RegWrite_M = 1'b1; RD_addr_M = 5'd0;
        RegWrite_W = 1'b1; RD_addr_W = 5'd0;
        RS_addr_E = 5'd0; RT_addr_E = 5'd0;
        #1;
        checks++;
        if (ctrl !== 6'b000000) begin
            $display("FAIL x0_ctrl: got %b exp %b", ctrl, 6'b000000); errors++;
        end
        checks++;
        if ({Fwd_A_E, Fwd_B_E} !== 4'b0000) begin
            $display("FAIL x0_fwd: got %b exp %b", {Fwd_A_E, Fwd_B_E}, 4'b0000); errors++;
        end
        tick(1);
        checks++;
        if (stall_cnt !== 32'd0) begin
            $display("FAIL x0_cnt: got %0d exp 0", stall_cnt); errors++;
        end
        idle_inputs();
    endtask

    task automatic test_forwarding();
        do_reset();
        RegWrite_M = 1'b1; RD_addr_M = 5'd7;
        RegWrite_W = 1'b1; RD_addr_W = 5'd7;
        RS_addr_E = 5'd7; RT_addr_E = 5'd7;
        #1;
        checks++;
        if ({Fwd_A_E, Fwd_B_E} !== 4'b1010) begin
            $display("FAIL fwd_mem: got %b exp %b", {Fwd_A_E, Fwd_B_E}, 4'b1010); errors++;
        end
        RegWrite_M = 1'b0;
        #1;
        checks++;
        if ({Fwd_A_E, Fwd_B_E} !== 4'b0101) begin
            $display("FAIL fwd_wb: got %b exp %b", {Fwd_A_E, Fwd_B_E}, 4'b0101); errors++;
        end
        RegWrite_W = 1'b0;
        #1;
        checks++;
        if ({Fwd_A_E, Fwd_B_E} !== 4'b0000) begin
            $display("FAIL fwd_none: got %b exp %b", {Fwd_A_E, Fwd_B_E}, 4'b0000); errors++;
        end
        // Split sources: rs1 from MEM, rs2 from WB
        RegWrite_M = 1'b1; RD_addr_M = 5'd7;
        RegWrite_W = 1'b1; RD_addr_W = 5'd3;
        RS_addr_E = 5'd7; RT_addr_E = 5'd3;
        #1;
        checks++;
        if ({Fwd_A_E, Fwd_B_E} !== 4'b1001) begin
            $display("FAIL fwd_split: got %b exp %b", {Fwd_A_E, Fwd_B_E}, 4'b1001); errors++;
        end
        RS_addr_E = 5'd3; RT_addr_E = 5'd7;
        #1;
        checks++;
        if ({Fwd_A_E, Fwd_B_E} !== 4'b0110) begin
            $display("FAIL fwd_swap: got %b exp %b", {Fwd_A_E, Fwd_B_E}, 4'b0110); errors++;
        end
        idle_inputs();
    endtask

    task automatic test_redirect_lu();
        do_reset();
        ResultSrc_E = 2'b01; RD_addr_E = 5'd5; RS_addr_D = 5'd5;
        PCSrc_E = 1'b1;
        #1;
        checks++;
        if (ctrl !== 6'b000011) begin
            $display("FAIL redir_ctrl: got %b exp %b", ctrl, 6'b000011); errors++;
        end
        tick(1);
        checks++;
        if ({stall_cnt, flush_cnt} !== {32'd0, 32'd1}) begin
            $display("FAIL redir_cnt: stall=%0d flush=%0d exp 0 1", stall_cnt, flush_cnt); errors++;
        end
        idle_inputs();
    endtask

    task automatic test_membusy_redirect();
        do_reset();
        MemBusy = 1'b1; PCSrc_E = 1'b1;
        ResultSrc_E = 2'b01; RD_addr_E = 5'd4; RT_addr_D = 5'd4;
        #1;
        checks++;
        if (ctrl !== 6'b111100) begin
            $display("FAIL busy_ctrl: got %b exp %b", ctrl, 6'b111100); errors++;
        end
        tick(3);
        checks++;
        if ({stall_cnt, flush_cnt} !== {32'd3, 32'd0}) begin
            $display("FAIL busy_cnt: stall=%0d flush=%0d exp 3 0", stall_cnt, flush_cnt); errors++;
        end
        MemBusy = 1'b0;
        #1;
        checks++;
        if (ctrl !== 6'b000011) begin
            $display("FAIL busy_drop_ctrl: got %b exp %b", ctrl, 6'b000011); errors++;
        end
        tick(1);
        checks++;
        if ({stall_cnt, flush_cnt} !== {32'd3, 32'd1}) begin
            $display("FAIL busy_drop_cnt: stall=%0d flush=%0d exp 3 1", stall_cnt, flush_cnt); errors++;
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        // Interrupted busy runs never reach the threshold
        MemBusy = 1'b1;
        tick(200);
        MemBusy = 1'b0;
        tick(1);
        MemBusy = 1'b1;
        tick(200);
        checks++;
        if (mem_timeout !== 1'b0) begin
            $display("FAIL timeout_interrupted: got %b exp 0", mem_timeout); errors++;
        end
        do_reset();
        MemBusy = 1'b1;
        tick(254);
        checks++;
        if (mem_timeout !== 1'b0) begin
            $display("FAIL timeout_254: got %b exp 0", mem_timeout); errors++;
        end
        tick(1);
        checks++;
        if (mem_timeout !== 1'b1) begin
            $display("FAIL timeout_255: got %b exp 1", mem_timeout); errors++;
        end
        tick(1);
        MemBusy = 1'b0;
        tick(3);
        checks++;
        if (mem_timeout !== 1'b1) begin
            $display("FAIL timeout_sticky: got %b exp 1", mem_timeout); errors++;
        end
        do_reset();
        checks++;
        if (mem_timeout !== 1'b0) begin
            $display("FAIL timeout_rst: got %b exp 0", mem_timeout); errors++;
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        MemBusy = 1'b1;
        tick(2);
        checks++;
        if ({stall_cnt, mem_timeout4} !== {32'd2, 1'b0}) begin
            $display("FAIL midrst_pre: stall=%0d to4=%b exp 2 0", stall_cnt, mem_timeout4); errors++;
        end
        RST = 1'b1;
        RegWrite_M = 1'b1; RD_addr_M = 5'd8; RS_addr_E = 5'd8;
        #1;
        checks++;
        if ({ctrl, Fwd_A_E, Fwd_B_E} !== 10'd0) begin
            $display("FAIL midrst_outs: got %b exp %b", {ctrl, Fwd_A_E, Fwd_B_E}, 10'd0); errors++;
        end
        tick(1);
        RST = 1'b0;
        checks++;
        if ({stall_cnt, flush_cnt} !== 64'd0) begin
            $display("FAIL midrst_cnt: stall=%0d flush=%0d exp 0 0", stall_cnt, flush_cnt); errors++;
        end
        // wait_cnt was cleared: two more busy edges stay below TIMEOUT=3 on dut4
        tick(2);
        checks++;
        if ({stall_cnt, mem_timeout4} !== {32'd2, 1'b0}) begin
            $display("FAIL midrst_wait_clr: stall=%0d to4=%b exp 2 0", stall_cnt, mem_timeout4); errors++;
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        MemBusy = 1'b1;
        tick(20);
        checks++;
        if (stall_cnt4 !== 4'd15) begin
            $display("FAIL sat_cnt4: got %0d exp 15", stall_cnt4); errors++;
        end
        checks++;
        if (stall_cnt !== 32'd20) begin
            $display("FAIL sat_cnt32: got %0d exp 20", stall_cnt); errors++;
        end
        checks++;
        if (mem_timeout4 !== 1'b1) begin
            $display("FAIL sat_timeout4: got %b exp 1", mem_timeout4); errors++;
        end
        // Flush counter saturates too
        do_reset();
        PCSrc_E = 1'b1;
        tick(18);
        checks++;
        if ({flush_cnt4, stall_cnt4} !== {4'd15, 4'd0}) begin
            $display("FAIL sat_flush4: flush=%0d stall=%0d exp 15 0", flush_cnt4, stall_cnt4); errors++;
        end
        idle_inputs();
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_x0_filter();
        test_forwarding();
        test_redirect_lu();
        test_membusy_redirect();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
